// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: shared types for the AXI4-Lite master slice.
//   resp_t     - AXI response encoding (OKAY/EXOKAY/SLVERR/DECERR)
//   wr_state_t - write-path FSM states
//   rd_state_t - read-path FSM states
package axi_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'b00,
        W_SEND = 2'b01,
        W_RESP = 2'b10
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'b00,
        R_ADDR = 2'b01,
        R_DATA = 2'b10
    } rd_state_t;

endpackage

// File: rtl/axi_lite_if.sv
// axi_lite_if: AXI4-Lite link bundle (clock and reset carried in the interface).
//   Parameters: ADDRESS_WIDTH, DATA_WIDTH (multiple of 8).
//   modport master: drives AW/W/AR VALID+payload, BREADY, RREADY.
//   modport slave : drives AW/W/AR READY, B and R channels.
interface axi_lite_if #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32
);
    logic                      ACLK;
    logic                      ARESETn;

    logic                      AWVALID;
    logic                      AWREADY;
    logic [ADDRESS_WIDTH-1:0]  AWADDR;

    logic                      WVALID;
    logic                      WREADY;
    logic [DATA_WIDTH-1:0]     WDATA;
    logic [DATA_WIDTH/8-1:0]   WSTRB;

    logic                      BVALID;
    logic                      BREADY;
    logic [1:0]                BRESP;

    logic                      ARVALID;
    logic                      ARREADY;
    logic [ADDRESS_WIDTH-1:0]  ARADDR;

    logic                      RVALID;
    logic                      RREADY;
    logic [DATA_WIDTH-1:0]     RDATA;
    logic [1:0]                RRESP;

    modport master (
        input  ACLK, ARESETn,
        output AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY, ARVALID, ARADDR, RREADY,
        input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );

    modport slave (
        input  ACLK, ARESETn,
        input  AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY, ARVALID, ARADDR, RREADY,
        output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );

endinterface

// File: rtl/axi_lite_watchdog.sv
// axi_lite_watchdog: loadable down-counter for response timeouts.
//   clk_i    - clock
//   rst_ni   - synchronous active-low reset
//   load_i   - reload the counter with TIMEOUT_CYCLES
//   run_i    - count down while high; counter clears while low
//   expire_o - high during the TIMEOUT_CYCLES-th cycle of running
module axi_lite_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic run_i,
    output logic expire_o
);
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CW'(TIMEOUT_CYCLES);
        end else if (!run_i) begin
            cnt_d = '0;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Loaded on the edge entering the wait state, so the count reads 1 on the
    // last permitted cycle and the abort edge ends exactly TIMEOUT_CYCLES
    // edges after entry.
    assign expire_o = run_i && (cnt_q == CW'(1));

endmodule

// File: rtl/axi4_lite_master.sv
// axi4_lite_master: AXI4-Lite initiator with independent single-outstanding
// write and read paths.
//   axi                         - axi_lite_if.master (ACLK, ARESETn sync active-low)
//   master_waddr/wdata/wstrb    - write payload, sampled with start_write
//   start_write / start_read    - request pulses, dropped while the path is busy
//   master_raddr                - read address, sampled with start_read
//   write_busy / read_busy      - path not idle
//   write_done / read_done      - one-cycle completion pulses
//   master_bresp                - latched BRESP
//   master_rdata / master_rresp - latched RDATA / RRESP
// Optional: AXI_LITE_MASTER_TIMEOUT_EN adds a per-path response watchdog
// (TIMEOUT_CYCLES) that aborts with SLVERR.
module axi4_lite_master
    import axi_lite_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDRESS_WIDTH  = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    axi_lite_if.master                 axi,
    input  logic [ADDRESS_WIDTH-1:0]   master_waddr,
    input  logic [DATA_WIDTH-1:0]      master_wdata,
    input  logic [DATA_WIDTH/8-1:0]    master_wstrb,
    input  logic                       start_write,
    input  logic [ADDRESS_WIDTH-1:0]   master_raddr,
    input  logic                       start_read,
    output logic                       write_busy,
    output logic                       read_busy,
    output logic                       write_done,
    output logic [1:0]                 master_bresp,
    output logic                       read_done,
    output logic [DATA_WIDTH-1:0]      master_rdata,
    output logic [1:0]                 master_rresp
);
    if ((DATA_WIDTH == 0) || ((DATA_WIDTH % 8) != 0)) begin : g_bad_data_width
        $error("axi4_lite_master: DATA_WIDTH must be a non-zero multiple of 8");
    end
    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("axi4_lite_master: TIMEOUT_CYCLES must be at least 1");
    end

    // ---------------- write path ----------------
    wr_state_t                 wstate_q, wstate_d;
    logic                      awvalid_q, awvalid_d;
    logic                      wvalid_q, wvalid_d;
    logic                      bready_q, bready_d;
    logic [ADDRESS_WIDTH-1:0]  awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [DATA_WIDTH/8-1:0]   wstrb_q, wstrb_d;
    logic [1:0]                bresp_q, bresp_d;
    logic                      wdone_q, wdone_d;
    logic                      w_expire;

    // ---------------- read path ----------------
    rd_state_t                 rstate_q, rstate_d;
    logic                      arvalid_q, arvalid_d;
    logic                      rready_q, rready_d;
    logic [ADDRESS_WIDTH-1:0]  araddr_q, araddr_d;
    logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
    logic [1:0]                rresp_q, rresp_d;
    logic                      rdone_q, rdone_d;
    logic                      r_expire;

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
    axi_lite_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wr_wdog (
        .clk_i    (axi.ACLK),
        .rst_ni   (axi.ARESETn),
        .load_i   ((wstate_q == W_SEND) && (wstate_d == W_RESP)),
        .run_i    (wstate_q == W_RESP),
        .expire_o (w_expire)
    );

    axi_lite_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rd_wdog (
        .clk_i    (axi.ACLK),
        .rst_ni   (axi.ARESETn),
        .load_i   ((rstate_q == R_ADDR) && (rstate_d == R_DATA)),
        .run_i    (rstate_q == R_DATA),
        .expire_o (r_expire)
    );
`else
    assign w_expire = 1'b0;
    assign r_expire = 1'b0;
`endif

    always_comb begin
        wstate_d  = wstate_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bresp_d   = bresp_q;
        wdone_d   = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                if (start_write) begin
                    awaddr_d  = master_waddr;
                    wdata_d   = master_wdata;
                    wstrb_d   = master_wstrb;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    wstate_d  = W_SEND;
                end
            end
            W_SEND: begin
                if (awvalid_q && axi.AWREADY) awvalid_d = 1'b0;
                if (wvalid_q && axi.WREADY)   wvalid_d  = 1'b0;
                // Both channels are finished once neither VALID survives this edge,
                // which covers either order and the same-cycle case.
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    wstate_d = W_RESP;
                end
            end
            W_RESP: begin
                if (bready_q && axi.BVALID) begin
                    bresp_d  = axi.BRESP;
                    wdone_d  = 1'b1;
                    bready_d = 1'b0;
                    wstate_d = W_IDLE;
                end else if (w_expire) begin
                    bresp_d  = SLVERR;
                    wdone_d  = 1'b1;
                    bready_d = 1'b0;
                    wstate_d = W_IDLE;
                end
            end
            default: begin
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                bready_d  = 1'b0;
                wstate_d  = W_IDLE;
            end
        endcase
    end

    always_comb begin
        rstate_d  = rstate_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        araddr_d  = araddr_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rdone_d   = 1'b0;
        case (rstate_q)
            R_IDLE: begin
                if (start_read) begin
                    araddr_d  = master_raddr;
                    arvalid_d = 1'b1;
                    rstate_d  = R_ADDR;
                end
            end
            R_ADDR: begin
                if (arvalid_q && axi.ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    rstate_d  = R_DATA;
                end
            end
            R_DATA: begin
                if (rready_q && axi.RVALID) begin
                    rdata_d  = axi.RDATA;
                    rresp_d  = axi.RRESP;
                    rdone_d  = 1'b1;
                    rready_d = 1'b0;
                    rstate_d = R_IDLE;
                end else if (r_expire) begin
                    rdata_d  = '0;
                    rresp_d  = SLVERR;
                    rdone_d  = 1'b1;
                    rready_d = 1'b0;
                    rstate_d = R_IDLE;
                end
            end
            default: begin
                arvalid_d = 1'b0;
                rready_d  = 1'b0;
                rstate_d  = R_IDLE;
            end
        endcase
    end

    always_ff @(posedge axi.ACLK) begin
        if (!axi.ARESETn) begin
            wstate_q  <= W_IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= '0;
            wdone_q   <= 1'b0;
            rstate_q  <= R_IDLE;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            araddr_q  <= '0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            rdone_q   <= 1'b0;
        end else begin
            wstate_q  <= wstate_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bresp_q   <= bresp_d;
            wdone_q   <= wdone_d;
            rstate_q  <= rstate_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            araddr_q  <= araddr_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rdone_q   <= rdone_d;
        end
    end

    assign axi.AWVALID   = awvalid_q;
    assign axi.AWADDR    = awaddr_q;
    assign axi.WVALID    = wvalid_q;
    assign axi.WDATA     = wdata_q;
    assign axi.WSTRB     = wstrb_q;
    assign axi.BREADY    = bready_q;
    assign axi.ARVALID   = arvalid_q;
    assign axi.ARADDR    = araddr_q;
    assign axi.RREADY    = rready_q;

    assign write_busy    = (wstate_q != W_IDLE);
    assign read_busy     = (rstate_q != R_IDLE);
    assign write_done    = wdone_q;
    assign master_bresp  = bresp_q;
    assign read_done     = rdone_q;
    assign master_rdata  = rdata_q;
    assign master_rresp  = rresp_q;

endmodule

// File: tb/tb_axi4_lite_master.sv
// tb_axi4_lite_master: self-checking bench for axi4_lite_master with a
// behavioural AXI4-Lite slave and a completion scoreboard.
module tb_axi4_lite_master;
    import axi_lite_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;
    localparam int unsigned TO = 8;

    axi_lite_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

    logic [AW-1:0] master_waddr, master_raddr;
    logic [DW-1:0] master_wdata, master_rdata;
    logic [SW-1:0] master_wstrb;
    logic          start_write, start_read;
    logic          write_busy, read_busy, write_done, read_done;
    logic [1:0]    master_bresp, master_rresp;

    axi4_lite_master #(
        .DATA_WIDTH     (DW),
        .ADDRESS_WIDTH  (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .axi          (axi),
        .master_waddr (master_waddr),
        .master_wdata (master_wdata),
        .master_wstrb (master_wstrb),
        .start_write  (start_write),
        .master_raddr (master_raddr),
        .start_read   (start_read),
        .write_busy   (write_busy),
        .read_busy    (read_busy),
        .write_done   (write_done),
        .master_bresp (master_bresp),
        .read_done    (read_done),
        .master_rdata (master_rdata),
        .master_rresp (master_rresp)
    );

    int checks = 0;
    int errors = 0;
    int wdone_cnt = 0;
    int rdone_cnt = 0;

    logic [1:0]    exp_bresp_q[$];
    logic [DW+1:0] exp_rd_q[$];   // {rresp, rdata}

    // Slave behaviour knobs
    int unsigned   aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
    bit            b_never = 0, r_never = 0;
    logic [1:0]    bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    logic [DW-1:0] rdata_cfg = '0;

    initial begin
        axi.ACLK = 1'b0;
        forever #5 axi.ACLK = ~axi.ACLK;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got stuck expected completion");
        $fatal(1, "global timeout");
    end

    // Behavioural slave: samples handshakes at negedge, updates just after posedge.
    initial begin
        int unsigned aw_wait, w_wait, ar_wait, b_wait, r_wait;
        bit aw_got, w_got, b_pend, r_pend;
        bit aw_hs, w_hs, ar_hs, b_hs, r_hs, aw_st, w_st, ar_st, rst_s;
        aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
        aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
        axi.AWREADY = 1'b0; axi.WREADY = 1'b0; axi.ARREADY = 1'b0;
        axi.BVALID = 1'b0; axi.BRESP = 2'b00; axi.RVALID = 1'b0;
        axi.RDATA = '0; axi.RRESP = 2'b00;
        forever begin
            @(negedge axi.ACLK);
            rst_s = axi.ARESETn;
            aw_hs = axi.AWVALID && axi.AWREADY;  aw_st = axi.AWVALID && !axi.AWREADY;
            w_hs  = axi.WVALID  && axi.WREADY;   w_st  = axi.WVALID  && !axi.WREADY;
            ar_hs = axi.ARVALID && axi.ARREADY;  ar_st = axi.ARVALID && !axi.ARREADY;
            b_hs  = axi.BVALID  && axi.BREADY;
            r_hs  = axi.RVALID  && axi.RREADY;
            @(posedge axi.ACLK);
            #1;
            if (!rst_s) begin
                aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
                aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
            end else begin
                if (aw_hs) begin aw_wait = 0; aw_got = 1; end else if (aw_st) aw_wait++;
                if (w_hs)  begin w_wait = 0;  w_got = 1;  end else if (w_st)  w_wait++;
                if (ar_hs) begin ar_wait = 0; r_pend = 1; r_wait = 0; end else if (ar_st) ar_wait++;
                if (b_hs) begin b_pend = 0; b_wait = 0; end else if (b_pend) b_wait++;
                if (r_hs) begin r_pend = 0; r_wait = 0; end else if (r_pend && !ar_hs) r_wait++;
                if (aw_got && w_got) begin b_pend = 1; b_wait = 0; aw_got = 0; w_got = 0; end
            end
            axi.AWREADY = (aw_wait >= aw_delay);
            axi.WREADY  = (w_wait >= w_delay);
            axi.ARREADY = (ar_wait >= ar_delay);
            axi.BVALID  = b_pend && !b_never && (b_wait >= b_delay);
            axi.BRESP   = bresp_cfg;
            axi.RVALID  = r_pend && !r_never && (r_wait >= r_delay);
            axi.RDATA   = rdata_cfg;
            axi.RRESP   = rresp_cfg;
        end
    end

    // Scoreboard: every completion pulse pops and compares one expectation.
    initial begin
        logic [1:0]    eb;
        logic [DW+1:0] er;
        forever begin
            @(negedge axi.ACLK);
            if (write_done === 1'b1) begin
                wdone_cnt++;
                checks++;
                if (exp_bresp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_write_unexpected: got write_done=1 bresp=%b, expected no completion", master_bresp);
                end else begin
                    eb = exp_bresp_q.pop_front();
                    if (master_bresp !== eb) begin
                        errors++;
                        $display("FAIL sb_bresp: got %b expected %b", master_bresp, eb);
                    end
                end
            end
            if (read_done === 1'b1) begin
                rdone_cnt++;
                checks++;
                if (exp_rd_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_read_unexpected: got read_done=1 rdata=%h, expected no completion", master_rdata);
                end else begin
                    er = exp_rd_q.pop_front();
                    if ({master_rresp, master_rdata} !== er) begin
                        errors++;
                        $display("FAIL sb_read: got resp=%b data=%h expected resp=%b data=%h",
                                 master_rresp, master_rdata, er[DW+1:DW], er[DW-1:0]);
                    end
                end
            end
        end
    end

    task automatic issue_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        @(posedge axi.ACLK); #1;
        master_waddr = a; master_wdata = d; master_wstrb = s; start_write = 1'b1;
        @(posedge axi.ACLK); #1;
        start_write = 1'b0;
    endtask

    task automatic issue_read(input logic [AW-1:0] a);
        @(posedge axi.ACLK); #1;
        master_raddr = a; start_read = 1'b1;
        @(posedge axi.ACLK); #1;
        start_read = 1'b0;
    endtask

    // Returns at the negedge where write_done is seen; lat counts negedges since the call.
    task automatic wait_write_done(input string name, input int max_cyc, output int lat);
        lat = 0;
        do begin
            @(negedge axi.ACLK);
            lat++;
        end while (write_done !== 1'b1 && lat < max_cyc);
        checks++;
        if (write_done !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: got no write_done in %0d cycles, expected a completion", name, max_cyc);
        end
    endtask

    task automatic test_reset;
        axi.ARESETn = 1'b0;
        repeat (3) @(negedge axi.ACLK);
        checks++;
        if ({axi.AWVALID, axi.WVALID, axi.ARVALID, axi.BREADY, axi.RREADY} !== 5'b0) begin
            errors++;
            $display("FAIL reset_handshake: got %b expected 00000",
                     {axi.AWVALID, axi.WVALID, axi.ARVALID, axi.BREADY, axi.RREADY});
        end
        checks++;
        if ({axi.AWADDR, axi.WDATA, axi.WSTRB, axi.ARADDR} !== '0) begin
            errors++;
            $display("FAIL reset_payload: got awaddr=%h wdata=%h wstrb=%h araddr=%h expected 0",
                     axi.AWADDR, axi.WDATA, axi.WSTRB, axi.ARADDR);
        end
        checks++;
        if ({write_busy, read_busy, write_done, read_done, master_bresp, master_rresp, master_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_status: got busy=%b%b done=%b%b bresp=%b rresp=%b rdata=%h expected 0",
                     write_busy, read_busy, write_done, read_done, master_bresp, master_rresp, master_rdata);
        end
        @(posedge axi.ACLK); #2;
        axi.ARESETn = 1'b1;
    endtask

    task automatic test_zero_wait_write;
        aw_delay = 0; w_delay = 0; b_delay = 0; bresp_cfg = 2'b00;
        exp_bresp_q.push_back(2'b00);
        issue_write(32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
        @(negedge axi.ACLK);   // after edge N
        checks++;
        if ({axi.AWVALID, axi.WVALID, write_busy, axi.AWADDR, axi.WDATA, axi.WSTRB} !==
            {3'b111, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF}) begin
            errors++;
            $display("FAIL zw_send: got aw=%b w=%b busy=%b addr=%h data=%h strb=%h expected 1 1 1 00000010 deadbeef f",
                     axi.AWVALID, axi.WVALID, write_busy, axi.AWADDR, axi.WDATA, axi.WSTRB);
        end
        @(negedge axi.ACLK);   // after edge N+1
        checks++;
        if ({axi.AWVALID, axi.WVALID, axi.BREADY} !== 3'b001) begin
            errors++;
            $display("FAIL zw_resp_entry: got awv/wv/bready=%b expected 001", {axi.AWVALID, axi.WVALID, axi.BREADY});
        end
        @(negedge axi.ACLK);   // after edge N+2
        checks++;
        if (write_done !== 1'b1) begin
            errors++;
            $display("FAIL zw_done_latency: got write_done=%b in cycle N+3 expected 1", write_done);
        end
        @(negedge axi.ACLK);
        checks++;
        if ({write_done, write_busy, axi.BREADY} !== 3'b000) begin
            errors++;
            $display("FAIL zw_after_done: got done/busy/bready=%b expected 000", {write_done, write_busy, axi.BREADY});
        end
    endtask

    task automatic test_skewed_write;
        int aw_hi, w_hi, w0;
        bit stable, seen;
        aw_delay = 5; w_delay = 0; b_delay = 0; bresp_cfg = 2'b11;
        aw_hi = 0; w_hi = 0; stable = 1; seen = 0; w0 = wdone_cnt;
        exp_bresp_q.push_back(2'b11);
        issue_write(32'h0000_0020, 32'hA5A5_0001, 4'h3);
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge axi.ACLK);
            if (axi.AWVALID === 1'b1) begin
                aw_hi++;
                if (axi.AWADDR !== 32'h0000_0020) stable = 0;
            end
            if (axi.WVALID === 1'b1) w_hi++;
            if (write_done === 1'b1) seen = 1;
        end
        checks++;
        if (aw_hi != 6 || !stable) begin
            errors++;
            $display("FAIL skew_awvalid: got %0d cycles high stable=%0d expected 6 cycles stable=1", aw_hi, stable);
        end
        checks++;
        if (w_hi != 1) begin
            errors++;
            $display("FAIL skew_wvalid: got %0d cycles high expected 1", w_hi);
        end
        repeat (3) @(negedge axi.ACLK);
        checks++;
        if (wdone_cnt - w0 != 1) begin
            errors++;
            $display("FAIL skew_done_count: got %0d write_done pulses expected 1", wdone_cnt - w0);
        end
        aw_delay = 0;
    endtask

    task automatic test_read_wait;
        int ar_hi, lat, r0;
        bit stable;
        ar_delay = 2; r_delay = 3; rdata_cfg = 32'h1234_5678; rresp_cfg = 2'b10;
        ar_hi = 0; lat = 0; stable = 1; r0 = rdone_cnt;
        exp_rd_q.push_back({2'b10, 32'h1234_5678});
        issue_read(32'h0000_0040);
        for (int i = 1; i <= 30 && lat == 0; i++) begin
            @(negedge axi.ACLK);
            if (axi.ARVALID === 1'b1) begin
                ar_hi++;
                if (axi.ARADDR !== 32'h0000_0040) stable = 0;
            end
            if (read_done === 1'b1) lat = i;
        end
        checks++;
        if (ar_hi != 3 || !stable) begin
            errors++;
            $display("FAIL rd_arvalid: got %0d cycles high stable=%0d expected 3 cycles stable=1", ar_hi, stable);
        end
        checks++;
        if (lat != 8) begin
            errors++;
            $display("FAIL rd_latency: got read_done at cycle %0d expected 8", lat);
        end
        rdata_cfg = 32'hFFFF_0000;
        repeat (3) @(negedge axi.ACLK);
        checks++;
        if (rdone_cnt - r0 != 1 || master_rdata !== 32'h1234_5678 || master_rresp !== 2'b10) begin
            errors++;
            $display("FAIL rd_hold: got pulses=%0d rdata=%h rresp=%b expected 1 12345678 10",
                     rdone_cnt - r0, master_rdata, master_rresp);
        end
        ar_delay = 0; r_delay = 0;
    endtask

    task automatic test_concurrent;
        int wlat, rlat, w0, r0;
        aw_delay = 0; w_delay = 0; b_delay = 2; ar_delay = 0; r_delay = 0;
        bresp_cfg = 2'b00; rresp_cfg = 2'b00; rdata_cfg = 32'hCAFE_0001;
        wlat = 0; rlat = 0; w0 = wdone_cnt; r0 = rdone_cnt;
        exp_bresp_q.push_back(2'b00);
        exp_rd_q.push_back({2'b00, 32'hCAFE_0001});
        @(posedge axi.ACLK); #1;
        master_waddr = 32'h0000_0100; master_wdata = 32'h1111_2222; master_wstrb = 4'hF;
        master_raddr = 32'h0000_0200;
        start_write = 1'b1; start_read = 1'b1;
        @(posedge axi.ACLK); #1;   // edge N: both accepted
        start_read = 1'b0;
        master_waddr = 32'h0000_0300; master_wdata = 32'h3333_4444;
        checks++;
        if ({write_busy, read_busy} !== 2'b11) begin
            errors++;
            $display("FAIL conc_busy: got write_busy/read_busy=%b expected 11", {write_busy, read_busy});
        end
        @(posedge axi.ACLK); #1;   // edge N+1: extra start while busy
        start_write = 1'b0;
        for (int i = 2; i <= 20; i++) begin
            @(negedge axi.ACLK);
            if (write_done === 1'b1 && wlat == 0) wlat = i;
            if (read_done === 1'b1 && rlat == 0) rlat = i;
        end
        checks++;
        if (rlat != 3 || wlat != 5) begin
            errors++;
            $display("FAIL conc_latency: got read at %0d write at %0d expected 3 and 5", rlat, wlat);
        end
        checks++;
        if (wdone_cnt - w0 != 1 || rdone_cnt - r0 != 1 || axi.AWADDR !== 32'h0000_0100) begin
            errors++;
            $display("FAIL conc_drop_extra: got wdone=%0d rdone=%0d awaddr=%h expected 1 1 00000100",
                     wdone_cnt - w0, rdone_cnt - r0, axi.AWADDR);
        end
        b_delay = 0;
    endtask

    task automatic test_back_to_back;
        int lat;
        aw_delay = 0; w_delay = 0; b_delay = 0; bresp_cfg = 2'b00;
        exp_bresp_q.push_back(2'b00);
        issue_write(32'h0000_0044, 32'h0BAD_F00D, 4'hC);
        wait_write_done("b2b_first", 10, lat);
        // Start in the same cycle that write_done is high.
        master_waddr = 32'h0000_0050; master_wdata = 32'h5555_AAAA; master_wstrb = 4'h1;
        start_write = 1'b1; bresp_cfg = 2'b01;
        exp_bresp_q.push_back(2'b01);
        @(posedge axi.ACLK); #1;
        start_write = 1'b0;
        @(negedge axi.ACLK);
        checks++;
        if (axi.AWVALID !== 1'b1 || axi.AWADDR !== 32'h0000_0050) begin
            errors++;
            $display("FAIL b2b_accept: got awvalid=%b awaddr=%h expected 1 00000050", axi.AWVALID, axi.AWADDR);
        end
        wait_write_done("b2b_second", 10, lat);
        bresp_cfg = 2'b00;
    endtask

    task automatic test_reset_mid_write;
        int w0;
        bit found;
        b_never = 1; found = 0;
        issue_write(32'h0000_0060, 32'h7777_8888, 4'hF);
        w0 = wdone_cnt;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge axi.ACLK);
            if (axi.BREADY === 1'b1) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL rstmid_reach_resp: got bready=%b expected 1 within 10 cycles", axi.BREADY);
        end
        @(posedge axi.ACLK); #2;
        axi.ARESETn = 1'b0;
        @(posedge axi.ACLK);
        @(negedge axi.ACLK);
        checks++;
        if ({axi.AWVALID, axi.WVALID, axi.ARVALID, axi.BREADY, axi.RREADY, write_busy, write_done} !== 7'b0
            || axi.AWADDR !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs: got v/r=%b busy=%b done=%b awaddr=%h expected all 0",
                     {axi.AWVALID, axi.WVALID, axi.ARVALID, axi.BREADY, axi.RREADY},
                     write_busy, write_done, axi.AWADDR);
        end
        @(posedge axi.ACLK); #2;
        axi.ARESETn = 1'b1;
        b_never = 0;
        repeat (4) @(negedge axi.ACLK);
        checks++;
        if (wdone_cnt != w0 || write_busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_no_done: got %0d write_done pulses busy=%b expected 0 0", wdone_cnt - w0, write_busy);
        end
    endtask

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
    task automatic test_timeout;
        int e, d, re, rd;
        b_never = 1; r_never = 1; e = 0; d = 0; re = 0; rd = 0;
        exp_bresp_q.push_back(2'b10);
        exp_rd_q.push_back({2'b10, {DW{1'b0}}});
        rdata_cfg = 32'hDEAD_DEAD;
        @(posedge axi.ACLK); #1;
        master_waddr = 32'h0000_0070; master_wdata = 32'h1; master_wstrb = 4'hF;
        master_raddr = 32'h0000_0074;
        start_write = 1'b1; start_read = 1'b1;
        @(posedge axi.ACLK); #1;
        start_write = 1'b0; start_read = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge axi.ACLK);
            if (axi.BREADY === 1'b1 && e == 0) e = i;
            if (write_done === 1'b1 && d == 0) d = i;
            if (axi.RREADY === 1'b1 && re == 0) re = i;
            if (read_done === 1'b1 && rd == 0) rd = i;
        end
        checks++;
        if (e == 0 || d - e != 8) begin
            errors++;
            $display("FAIL to_write_latency: got write_done %0d cycles after W_RESP entry cycle expected 8", d - e);
        end
        checks++;
        if (re == 0 || rd - re != 8) begin
            errors++;
            $display("FAIL to_read_latency: got read_done %0d cycles after R_DATA entry cycle expected 8", rd - re);
        end
        @(posedge axi.ACLK); #2;
        axi.ARESETn = 1'b0;
        @(posedge axi.ACLK); #2;
        axi.ARESETn = 1'b1;
        b_never = 0; r_never = 0;
    endtask
`endif

    initial begin
        axi.ARESETn = 1'b0;
        master_waddr = '0; master_wdata = '0; master_wstrb = '0; master_raddr = '0;
        start_write = 1'b0; start_read = 1'b0;
        test_reset();
        test_zero_wait_write();
        test_skewed_write();
        test_read_wait();
        test_concurrent();
        test_back_to_back();
        test_reset_mid_write();
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        repeat (3) @(negedge axi.ACLK);
        checks++;
        if (exp_bresp_q.size() != 0 || exp_rd_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d writes and %0d reads outstanding expected 0 0",
                     exp_bresp_q.size(), exp_rd_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
